// File: rtl/itcm_arb_if.sv
// Command/response channel shared by the core ports and itcm_ctrl.
// master drives commands and accepts responses; slave does the reverse.
interface itcm_arb_if #(
   parameter int AW = 16,
   parameter int DW = 32,
   parameter int MW = 4
);
   logic          cmd_valid;
   logic          cmd_ready;
   logic          cmd_read;
   logic [AW-1:0] cmd_addr;
   logic [DW-1:0] cmd_wdata;
   logic [MW-1:0] cmd_wmask;
   logic          rsp_valid;
   logic          rsp_ready;
   logic [DW-1:0] rsp_rdata;

   modport master (
      output cmd_valid, cmd_read, cmd_addr,
      output cmd_wdata, cmd_wmask, rsp_ready,
      input  cmd_ready, rsp_valid, rsp_rdata
   );

   modport slave (
      input  cmd_valid, cmd_read, cmd_addr,
      input  cmd_wdata, cmd_wmask, rsp_ready,
      output cmd_ready, rsp_valid, rsp_rdata
   );
endinterface

// File: rtl/itcm_arb.sv
// 2:1 round-robin arbiter between IFU (m0) / LSU (m1) and itcm_ctrl.
// An in-order ID FIFO steers each response back to its requester.
module itcm_arb #(
   parameter int AW   = 16,
   parameter int DW   = 32,
   parameter int MW   = 4,
   parameter int OUTS = 2
) (
   input  logic        clk,
   input  logic        rst,
   itcm_arb_if.slave   m0,
   itcm_arb_if.slave   m1,
   itcm_arb_if.master  s,
   output logic        err_noreq
);

   localparam int PW = (OUTS > 1) ? $clog2(OUTS) : 1;
   localparam int CW = $clog2(OUTS + 1);

   logic [PW-1:0] rd_q, rd_d;
   logic [PW-1:0] wr_q, wr_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          fifo_q [OUTS];
   logic          fifo_d [OUTS];
   logic          last_q, last_d;
   logic          lock_q, lock_d;
   logic          lgnt_q, lgnt_d;
   logic          err_q, err_d;

   logic gnt;
   logic gvalid;
   logic full;
   logic nempty;
   logic head;
   logic push;
   logic pop;

   function automatic logic [PW-1:0] ptr_inc(
      input logic [PW-1:0] p
   );
      return (p == PW'(OUTS - 1)) ? '0 : p + PW'(1);
   endfunction

   // A stalled command keeps its grant so the payload cannot switch.
   always_comb begin
      gnt = ~last_q;
      if (lock_q)
         gnt = lgnt_q;
      else if (m0.cmd_valid & ~m1.cmd_valid)
         gnt = 1'b0;
      else if (m1.cmd_valid & ~m0.cmd_valid)
         gnt = 1'b1;
   end

   assign gvalid = gnt ? m1.cmd_valid : m0.cmd_valid;
   assign full   = (cnt_q == CW'(OUTS));
   assign nempty = (cnt_q != '0);
   assign head   = fifo_q[rd_q];

   assign s.cmd_valid = ~rst & gvalid & ~full;
   assign s.cmd_read  = gnt ? m1.cmd_read  : m0.cmd_read;
   assign s.cmd_addr  = gnt ? m1.cmd_addr  : m0.cmd_addr;
   assign s.cmd_wdata = gnt ? m1.cmd_wdata : m0.cmd_wdata;
   assign s.cmd_wmask = gnt ? m1.cmd_wmask : m0.cmd_wmask;

   assign m0.cmd_ready = ~rst & ~gnt & s.cmd_ready & ~full;
   assign m1.cmd_ready = ~rst &  gnt & s.cmd_ready & ~full;

   assign m0.rsp_valid = ~rst & s.rsp_valid & nempty & ~head;
   assign m1.rsp_valid = ~rst & s.rsp_valid & nempty &  head;
   assign m0.rsp_rdata = s.rsp_rdata;
   assign m1.rsp_rdata = s.rsp_rdata;

   // With nothing outstanding, stray responses are swallowed.
   assign s.rsp_ready = ~rst &
      (nempty ? (head ? m1.rsp_ready : m0.rsp_ready) : 1'b1);

   assign push = s.cmd_valid & s.cmd_ready;
   assign pop  = s.rsp_valid & s.rsp_ready & nempty;

   always_comb begin
      fifo_d = fifo_q;
      wr_d   = wr_q;
      rd_d   = rd_q;
      last_d = last_q;
      lock_d = lock_q;
      lgnt_d = lgnt_q;
      cnt_d  = cnt_q + CW'(push) - CW'(pop);
      err_d  = err_q | (s.rsp_valid & ~nempty);
      if (push) begin
         fifo_d[wr_q] = gnt;
         wr_d         = ptr_inc(wr_q);
         last_d       = gnt;
         lock_d       = 1'b0;
      end else if (s.cmd_valid & ~s.cmd_ready) begin
         lock_d = 1'b1;
         lgnt_d = gnt;
      end
      if (pop)
         rd_d = ptr_inc(rd_q);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         fifo_q <= '{default: 1'b0};
         wr_q   <= '0;
         rd_q   <= '0;
         cnt_q  <= '0;
         last_q <= 1'b1;
         lock_q <= 1'b0;
         lgnt_q <= 1'b0;
         err_q  <= 1'b0;
      end else begin
         fifo_q <= fifo_d;
         wr_q   <= wr_d;
         rd_q   <= rd_d;
         cnt_q  <= cnt_d;
         last_q <= last_d;
         lock_q <= lock_d;
         lgnt_q <= lgnt_d;
         err_q  <= err_d;
      end
   end

   assign err_noreq = err_q;

endmodule
